// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, load/store requester and memory-port signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic              ls_signed;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_done;
  logic              ls_err;
  logic [DATA_W-1:0] ls_rdata;

  logic              en_mem;
  logic [1:0]        W_R_mem;
  logic [1:0]        wordsize_mem;
  logic              sign_mem;
  logic [ADDR_W-1:0] addr_mem;
  logic [DATA_W-1:0] wdata_mem;
  logic [DATA_W-1:0] rdata_mem;
  logic              busy_mem;
  logic              done_mem;

  modport slave (
    input  if_req, if_addr,
    output if_done, if_err, if_rdata,
    input  ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
    output ls_done, ls_err, ls_rdata,
    output en_mem, W_R_mem, wordsize_mem, sign_mem, addr_mem, wdata_mem,
    input  rdata_mem, busy_mem, done_mem
  );

  modport master (
    output if_req, if_addr,
    input  if_done, if_err, if_rdata,
    output ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
    input  ls_done, ls_err, ls_rdata,
    input  en_mem, W_R_mem, wordsize_mem, sign_mem, addr_mem, wdata_mem,
    output rdata_mem, busy_mem, done_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch (IF) and load/store (LS), one access at a time.
// Handshake: a requester holds req (and its fields) until its 1-cycle done pulse; the memory holds off new
// accesses with busy_mem (checked only when idle) and ends an access with a 1-cycle done_mem.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic [1:0]         state_dbg   // 0 idle, 1 access, 2 release
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_ls_q, owner_ls_d;
  logic              en_mem_q, en_mem_d;
  logic [1:0]        w_r_q, w_r_d;
  logic [1:0]        wordsize_q, wordsize_d;
  logic              sign_q, sign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_done_q, if_done_d;
  logic              if_err_q, if_err_d;
  logic              ls_done_q, ls_done_d;
  logic              ls_err_q, ls_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              grant_ls;
  logic              finish;
  logic              timed_out;

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    en_mem_d   = en_mem_q;
    w_r_d      = w_r_q;
    wordsize_d = wordsize_q;
    sign_d     = sign_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    ls_done_d  = 1'b0;
    ls_err_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    grant_ls   = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.busy_mem && (bus.if_req || bus.ls_req)) begin
          // LS normally wins; a starved IF is forced through once wait_cnt saturates.
          grant_ls   = bus.ls_req && !(bus.if_req && (wait_cnt_q == WAIT_W'(MAX_WAIT)));
          state_d    = S_ACCESS;
          owner_ls_d = grant_ls;
          en_mem_d   = 1'b1;
          tmo_cnt_d  = '0;
          if (grant_ls) begin
            w_r_d      = bus.ls_we ? 2'b10 : 2'b01;
            wordsize_d = (bus.ls_size == 2'b11) ? 2'b10 : bus.ls_size;
            sign_d     = bus.ls_signed;
            addr_d     = bus.ls_addr;
            wdata_d    = bus.ls_wdata;
            if (bus.if_req && (wait_cnt_q != WAIT_W'(MAX_WAIT)))
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end else begin
            w_r_d      = 2'b01;
            wordsize_d = 2'b10;
            sign_d     = 1'b0;
            addr_d     = bus.if_addr;
            wdata_d    = '0;
            wait_cnt_d = '0;
          end
        end
      end

      S_ACCESS: begin
        if (bus.done_mem) begin
          finish = 1'b1;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        if (finish) begin
          state_d   = S_RELEASE;
          en_mem_d  = 1'b0;
          w_r_d     = 2'b00;
          tmo_cnt_d = '0;
          if (owner_ls_q) begin
            ls_done_d = 1'b1;
            ls_err_d  = timed_out;
            if (!timed_out) ls_rdata_d = bus.rdata_mem;
          end else begin
            if_done_d = 1'b1;
            if_err_d  = timed_out;
            if (!timed_out) if_rdata_d = bus.rdata_mem;
          end
        end
      end

      S_RELEASE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_ls_q <= 1'b0;
      en_mem_q   <= 1'b0;
      w_r_q      <= 2'b00;
      wordsize_q <= 2'b00;
      sign_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      ls_done_q  <= 1'b0;
      ls_err_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      en_mem_q   <= en_mem_d;
      w_r_q      <= w_r_d;
      wordsize_q <= wordsize_d;
      sign_q     <= sign_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      ls_done_q  <= ls_done_d;
      ls_err_q   <= ls_err_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign bus.en_mem       = en_mem_q;
  assign bus.W_R_mem      = w_r_q;
  assign bus.wordsize_mem = wordsize_q;
  assign bus.sign_mem     = sign_q;
  assign bus.addr_mem     = addr_q;
  assign bus.wdata_mem    = wdata_q;
  assign bus.if_done      = if_done_q;
  assign bus.if_err       = if_err_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.ls_done      = ls_done_q;
  assign bus.ls_err       = ls_err_q;
  assign bus.ls_rdata     = ls_rdata_q;
  assign state_dbg        = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized IF/LS traffic against a
// transaction-level model of the arbitration and read-data capture rules.
module tb_mem_port_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 12;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [1:0] state_dbg;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state: consecutive LS wins while IF waited, last captured data per requester
  int            model_wait;
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_ls_rdata;
  logic [0:0]    exp_q[$];   // expected grant owners, 1 = LS

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.ls_req    = 1'b0;
    bus.ls_we     = 1'b0;
    bus.ls_size   = 2'b00;
    bus.ls_signed = 1'b0;
    bus.ls_addr   = '0;
    bus.ls_wdata  = '0;
    bus.rdata_mem = '0;
    bus.busy_mem  = 1'b0;
    bus.done_mem  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_wait   = 0;
    exp_if_rdata = '0;
    exp_ls_rdata = '0;
  endtask

  // Rule: LS wins when requesting unless IF is also waiting and has lost MAX_WAIT times in a row.
  task automatic model_grant(input bit ifr, input bit lsr, output bit ls_wins);
    ls_wins = lsr && !(ifr && model_wait == MAX_WAIT);
    if (ls_wins) begin
      if (ifr && model_wait < MAX_WAIT) model_wait++;
    end else begin
      model_wait = 0;
    end
  endtask

  task automatic check_grant(input string tag, input bit ls_wins);
    logic [1:0] exp_wr;
    logic [1:0] exp_sz;
    exp_wr = (ls_wins && bus.ls_we) ? 2'b10 : 2'b01;
    exp_sz = !ls_wins ? 2'b10 : ((bus.ls_size == 2'b11) ? 2'b10 : bus.ls_size);
    chk({tag, ".en"}, bus.en_mem, 1);
    chk({tag, ".wr"}, bus.W_R_mem, exp_wr);
    chk({tag, ".size"}, bus.wordsize_mem, exp_sz);
    chk({tag, ".sign"}, bus.sign_mem, ls_wins ? bus.ls_signed : 1'b0);
    chk({tag, ".addr"}, bus.addr_mem, ls_wins ? bus.ls_addr : bus.if_addr);
    if (ls_wins && bus.ls_we) chk({tag, ".wdata"}, bus.wdata_mem, bus.ls_wdata);
  endtask

  // Memory driver: wait dly cycles, then a 1-cycle done_mem carrying rd.
  task automatic serve(input int dly, input logic [DW-1:0] rd);
    repeat (dly) tick();
    bus.done_mem  = 1'b1;
    bus.rdata_mem = rd;
    tick();
    bus.done_mem  = 1'b0;
    bus.rdata_mem = $urandom;
  endtask

  task automatic check_done(input string tag, input bit ls_owner, input bit err);
    chk({tag, ".if_done"}, bus.if_done, !ls_owner);
    chk({tag, ".ls_done"}, bus.ls_done, ls_owner);
    chk({tag, ".if_err"}, bus.if_err, !ls_owner && err);
    chk({tag, ".ls_err"}, bus.ls_err, ls_owner && err);
    chk({tag, ".en_off"}, bus.en_mem, 0);
    chk({tag, ".wr_idle"}, bus.W_R_mem, 2'b00);
    chk({tag, ".if_rdata"}, bus.if_rdata, exp_if_rdata);
    chk({tag, ".ls_rdata"}, bus.ls_rdata, exp_ls_rdata);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".en"}, bus.en_mem, 0);
    chk({tag, ".wr"}, bus.W_R_mem, 0);
    chk({tag, ".size"}, bus.wordsize_mem, 0);
    chk({tag, ".sign"}, bus.sign_mem, 0);
    chk({tag, ".addr"}, bus.addr_mem, 0);
    chk({tag, ".wdata"}, bus.wdata_mem, 0);
    chk({tag, ".dones"}, {bus.if_done, bus.if_err, bus.ls_done, bus.ls_err}, 0);
    chk({tag, ".if_rdata"}, bus.if_rdata, 0);
    chk({tag, ".ls_rdata"}, bus.ls_rdata, 0);
    chk({tag, ".state_idle"}, state_dbg, 0);
  endtask

  initial begin
    bit            ls_wins;
    logic [DW-1:0] rd;
    int            cnt;
    int            guard;

    idle_inputs();
    do_reset();
    check_all_zero("reset");

    // 1: fetch, done_mem 3 cycles after grant
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    tick();
    model_grant(1'b1, 1'b0, ls_wins);
    check_grant("t1_grant", ls_wins);
    serve(2, 32'hDEADBEEF);
    exp_if_rdata = 32'hDEADBEEF;
    check_done("t1_done", 1'b0, 1'b0);
    bus.if_req = 1'b0;
    tick();
    chk("t1_pulse_1cyc", bus.if_done, 0);

    // 2: half-word store
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_size  = 2'b01;
    bus.ls_addr  = 32'h204;
    bus.ls_wdata = 32'h1234;
    tick();
    model_grant(1'b0, 1'b1, ls_wins);
    check_grant("t2_grant", ls_wins);
    rd = $urandom;
    serve(1, rd);
    exp_ls_rdata = rd;
    check_done("t2_done", 1'b1, 1'b0);
    bus.ls_req = 1'b0;
    tick();

    // 3: both held, immediate done_mem -> LS x MAX_WAIT then IF, with a release gap each time
    do_reset();
    for (int k = 0; k < 2 * (MAX_WAIT + 1); k++)
      exp_q.push_back((k % (MAX_WAIT + 1)) != MAX_WAIT);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h400;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b1;
    bus.ls_addr = 32'h800;
    while (exp_q.size() > 0) begin
      logic [0:0] exp_ls;
      exp_ls = exp_q.pop_front();
      tick();
      chk("t3_owner_wr", bus.W_R_mem, exp_ls ? 2'b10 : 2'b01);
      chk("t3_owner_addr", bus.addr_mem, exp_ls ? 32'h800 : 32'h400);
      rd = $urandom;
      serve(0, rd);
      if (exp_ls) exp_ls_rdata = rd; else exp_if_rdata = rd;
      check_done("t3_done", exp_ls, 1'b0);
      tick();
      chk("t3_release_gap", bus.en_mem, 0);
    end
    model_wait  = 0;
    bus.if_req  = 1'b0;
    bus.ls_req  = 1'b0;
    bus.ls_we   = 1'b0;
    tick();

    // 4: load with no done_mem -> timeout after TIMEOUT access cycles
    bus.ls_req  = 1'b1;
    bus.ls_size = 2'b10;
    bus.ls_addr = $urandom;
    tick();
    model_grant(1'b0, 1'b1, ls_wins);
    check_grant("t4_grant", ls_wins);
    cnt   = 0;
    guard = 0;
    while (bus.en_mem && !bus.ls_done && guard < 10 * TIMEOUT) begin
      cnt++;
      guard++;
      tick();
    end
    chk("t4_access_cycles", cnt, TIMEOUT);
    check_done("t4_timeout", 1'b1, 1'b1);
    bus.ls_req = 1'b0;
    tick();
    bus.ls_req = 1'b1;
    tick();
    model_grant(1'b0, 1'b1, ls_wins);
    check_grant("t4_retry_grant", ls_wins);
    rd = $urandom;
    serve(2, rd);
    exp_ls_rdata = rd;
    check_done("t4_retry_done", 1'b1, 1'b0);
    bus.ls_req = 1'b0;
    tick();

    // 5: busy_mem holds off a pending fetch
    bus.busy_mem = 1'b1;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h3C0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_busy_hold", bus.en_mem, 0);
    end
    bus.busy_mem = 1'b0;
    tick();
    model_grant(1'b1, 1'b0, ls_wins);
    check_grant("t5_grant", ls_wins);
    rd = $urandom;
    serve(1, rd);
    exp_if_rdata = rd;
    check_done("t5_done", 1'b0, 1'b0);
    bus.if_req = 1'b0;
    tick();

    // 6: reset mid-access, then a stray done_mem
    bus.ls_req  = 1'b1;
    bus.ls_addr = 32'h55AA;
    tick();
    chk("t6_grant", bus.en_mem, 1);
    tick();
    reset      = 1'b1;
    bus.ls_req = 1'b0;
    tick();
    reset        = 1'b0;
    model_wait   = 0;
    exp_if_rdata = '0;
    exp_ls_rdata = '0;
    check_all_zero("t6_in_reset");
    serve(0, 32'hCAFEF00D);
    check_all_zero("t6_after_done");

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      bit ifr;
      bit lsr;
      ifr = 1'($urandom_range(0, 1));
      lsr = ifr ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.if_req    = ifr;
      bus.if_addr   = $urandom;
      bus.ls_req    = lsr;
      bus.ls_we     = 1'($urandom_range(0, 1));
      bus.ls_size   = 2'($urandom_range(0, 3));
      bus.ls_signed = 1'($urandom_range(0, 1));
      bus.ls_addr   = $urandom;
      bus.ls_wdata  = $urandom;
      bus.busy_mem  = 1'($urandom_range(0, 1));
      if (bus.busy_mem) begin
        repeat ($urandom_range(1, 3)) begin
          tick();
          chk("rnd_busy_hold", bus.en_mem, 0);
        end
        bus.busy_mem = 1'b0;
      end
      tick();
      model_grant(ifr, lsr, ls_wins);
      check_grant("rnd_grant", ls_wins);
      rd = $urandom;
      serve($urandom_range(0, 3), rd);
      if (ls_wins) exp_ls_rdata = rd; else exp_if_rdata = rd;
      check_done("rnd_done", ls_wins, 1'b0);
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
